// File: rtl/dp_bram_port_arbiter.sv
// Round-robin arbiter sharing BRAM port A between NUM_REQ valid/ready requesters.
// Each command yields exactly one read-first response, two cycles after its grant.
module dp_bram_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned NUM_REQ    = 2
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_REQ-1:0]               cmd_valid,
  output logic [NUM_REQ-1:0]               cmd_ready,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    cmd_wstrb,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    cmd_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  input  logic [NUM_REQ-1:0]               rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0]    rsp_data,
  output logic [STRB_WIDTH-1:0]            bram_wr_en,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [DATA_WIDTH-1:0]            bram_wdata,
  input  logic [DATA_WIDTH-1:0]            bram_rdata
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            pend;
  logic [NUM_REQ-1:0]            rsp_vld_q;
  logic [NUM_REQ-1:0]            eligible;
  logic [NUM_REQ-1:0]            grant;
  logic [PW-1:0]                 rr_ptr;
  logic [PW-1:0]                 rr_next;
  logic [PW-1:0]                 gidx;
  logic [PW-1:0]                 scan;
  logic                          grant_any;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [ADDR_WIDTH-1:0]         sel_addr;
  logic [DATA_WIDTH-1:0]         wdata_q;
  logic [DATA_WIDTH-1:0]         sel_wdata;
  logic [STRB_WIDTH-1:0]         sel_strb;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_q;

  // Only registered state gates eligibility, so cmd_ready never sees rsp_ready.
  assign eligible = cmd_valid & ~pend & ~rsp_vld_q;

  always_comb begin
    grant_any = 1'b0;
    gidx      = '0;
    scan      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = PW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && eligible[scan]) begin
        grant_any = 1'b1;
        gidx      = scan;
      end
    end
    grant_any = grant_any & aresetn;
  end

  always_comb begin
    grant = '0;
    if (grant_any) grant[gidx] = 1'b1;
  end

  assign cmd_ready = grant;
  assign rr_next   = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + PW'(1);

  assign sel_addr  = cmd_addr[32'(gidx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = cmd_wdata[32'(gidx) * DATA_WIDTH +: DATA_WIDTH];
  assign sel_strb  = cmd_wstrb[32'(gidx) * STRB_WIDTH +: STRB_WIDTH];

  // Address/data hold the last granted command when idle; only wr_en is forced low.
  assign bram_addr  = grant_any ? sel_addr  : addr_q;
  assign bram_wdata = grant_any ? sel_wdata : wdata_q;
  assign bram_wr_en = grant_any ? sel_strb  : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pend       <= '0;
      rsp_vld_q  <= '0;
      rr_ptr     <= '0;
      rsp_data_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      pend <= grant;
      if (grant_any) begin
        rr_ptr  <= rr_next;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (pend[i]) begin
          rsp_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= bram_rdata;
          rsp_vld_q[i]                           <= 1'b1;
        end else if (rsp_ready[i]) begin
          rsp_vld_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_dp_bram_port_arbiter.sv
// Directed bench for dp_bram_port_arbiter with a read-first byte-write BRAM model.
// Table of single transactions plus hand sequences for arbitration, backpressure and reset.
module tb_dp_bram_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned SW = 4;
  localparam int unsigned NR = 2;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NR-1:0]     cmd_valid;
  logic [NR-1:0]     cmd_ready;
  logic [NR*SW-1:0]  cmd_wstrb;
  logic [NR*AW-1:0]  cmd_addr;
  logic [NR*DW-1:0]  cmd_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [NR*DW-1:0]  rsp_data;
  logic [SW-1:0]     bram_wr_en;
  logic [AW-1:0]     bram_addr;
  logic [DW-1:0]     bram_wdata;
  logic [DW-1:0]     bram_rdata;
  logic              init_mem;

  logic [DW-1:0]     mem [0:255];

  int n_vec = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  dp_bram_port_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .STRB_WIDTH (SW),
    .NUM_REQ    (NR)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_wstrb  (cmd_wstrb),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .bram_wr_en (bram_wr_en),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  // Read-first BRAM port A, one-cycle registered read, byte writes.
  always @(posedge aclk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else begin
      bram_rdata <= mem[bram_addr[7:0]];
      for (int b = 0; b < int'(SW); b++)
        if (bram_wr_en[b]) mem[bram_addr[7:0]][8*b +: 8] <= bram_wdata[8*b +: 8];
    end
  end

  typedef struct {
    int unsigned   req;
    logic [SW-1:0] strb;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cmd(input int unsigned r, input logic [SW-1:0] strb,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    cmd_wstrb[r*SW +: SW] = strb;
    cmd_addr[r*AW +: AW]  = addr;
    cmd_wdata[r*DW +: DW] = wd;
  endtask

  task automatic drain();
    repeat (5) @(posedge aclk);
    #1;
  endtask

  task automatic do_txn(input int unsigned r, input logic [SW-1:0] strb, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp);
    bit got;
    got = 1'b0;
    @(posedge aclk); #1;
    set_cmd(r, strb, addr, wd);
    cmd_valid[r] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(negedge aclk);
      if (cmd_ready[r]) begin
        got = 1'b1;
        break;
      end
    end
    chk("grant", 32'(got), 32'd1);
    if (!got) begin
      cmd_valid[r] = 1'b0;
      return;
    end
    chk("grant_wr_en", 32'(bram_wr_en), 32'(strb));
    chk("grant_addr", 32'(bram_addr), 32'(addr));
    @(posedge aclk); #1;
    cmd_valid[r] = 1'b0;
    @(negedge aclk);
    chk("rsp_early", 32'(rsp_valid[r]), 32'd0);
    chk("idle_wr_en", 32'(bram_wr_en), 32'd0);
    chk("idle_addr_hold", 32'(bram_addr), 32'(addr));
    @(negedge aclk);
    chk("rsp_valid", 32'(rsp_valid[r]), 32'd1);
    chk("rsp_data", rsp_data[r*DW +: DW], exp);
    @(negedge aclk);
    chk("rsp_clear", 32'(rsp_valid[r]), 32'd0);
  endtask

  initial begin
    int  last, ngr, gap_bad, g0_cnt, last0, wait_ok;
    bit  both, alt_ok, stable_ok, no_g1;
    bit  [NR-1:0] any_rsp;
    logic [3:0] seq;

    vecs[0] = '{0, 4'hF, 16'h0010, 32'hDEADBEEF, 32'hA500_0010};
    vecs[1] = '{1, 4'h0, 16'h0010, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{0, 4'hF, 16'h0020, 32'h11223344, 32'hA500_0020};
    vecs[3] = '{1, 4'h2, 16'h0020, 32'hAAAAAAAA, 32'h11223344};
    vecs[4] = '{0, 4'h0, 16'h0020, 32'h0,        32'h1122AA44};
    vecs[5] = '{1, 4'h0, 16'h0030, 32'h0,        32'hA500_0030};
    vecs[6] = '{0, 4'h8, 16'h0030, 32'h77000000, 32'hA500_0030};
    vecs[7] = '{1, 4'h0, 16'h0030, 32'h0,        32'h77000030};
    vecs[8] = '{0, 4'h1, 16'h00FF, 32'h000000EE, 32'hA500_00FF};
    vecs[9] = '{1, 4'h0, 16'h00FF, 32'h0,        32'hA500_00EE};

    aresetn   = 1'b0;
    init_mem  = 1'b1;
    cmd_valid = 2'b11;
    cmd_wstrb = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 2'b11;

    repeat (2) @(posedge aclk);
    #1 init_mem = 1'b0;
    @(negedge aclk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_wr_en", 32'(bram_wr_en), 32'd0);
    chk("rst_rsp_data", rsp_data[31:0], 32'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_first_grant", 32'(cmd_ready), 32'd1);
    @(posedge aclk); #1 cmd_valid = '0;
    drain();

    for (int v = 0; v < 10; v++)
      do_txn(vecs[v].req, vecs[v].strb, vecs[v].addr, vecs[v].wdata, vecs[v].exp);
    drain();

    // Round-robin with both requesters continuously valid.
    set_cmd(0, 4'h0, 16'h0040, 32'h0);
    set_cmd(1, 4'h0, 16'h0041, 32'h0);
    cmd_valid = 2'b11;
    last = -1; ngr = 0; both = 1'b0; alt_ok = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge aclk);
      if (cmd_ready == 2'b11) both = 1'b1;
      else if (cmd_ready != 2'b00) begin
        if (int'(cmd_ready[1]) == last) alt_ok = 1'b0;
        last = int'(cmd_ready[1]);
        ngr++;
      end
    end
    chk("rr_no_double", 32'(both), 32'd0);
    chk("rr_alternate", 32'(alt_ok), 32'd1);
    chk("rr_count", 32'(ngr), 32'd8);
    @(posedge aclk); #1 cmd_valid = '0;
    drain();

    // Backpressure on requester 1 while requester 0 keeps issuing.
    rsp_ready = 2'b01;
    set_cmd(0, 4'h0, 16'h0020, 32'h0);
    set_cmd(1, 4'h0, 16'h0010, 32'h0);
    cmd_valid = 2'b11;
    wait_ok = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge aclk);
      if (rsp_valid[1]) begin
        wait_ok = 1;
        break;
      end
    end
    chk("bp_rsp_seen", 32'(wait_ok), 32'd1);
    stable_ok = 1'b1; no_g1 = 1'b1; gap_bad = 0; g0_cnt = 0; last0 = -1;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge aclk);
      if (!rsp_valid[1] || rsp_data[DW +: DW] !== 32'hDEADBEEF) stable_ok = 1'b0;
      if (cmd_ready[1]) no_g1 = 1'b0;
      if (cmd_ready[0]) begin
        if (last0 >= 0 && c - last0 != 3) gap_bad++;
        last0 = c;
        g0_cnt++;
      end
    end
    chk("bp_rsp_stable", 32'(stable_ok), 32'd1);
    chk("bp_no_grant1", 32'(no_g1), 32'd1);
    chk("bp_req0_period", 32'(gap_bad), 32'd0);
    chk("bp_req0_served", 32'(g0_cnt >= 3), 32'd1);
    @(posedge aclk); #1;
    rsp_ready = 2'b11;
    cmd_valid = '0;
    drain();

    // Handshake and new cmd_valid together: grant only on the following cycle.
    set_cmd(1, 4'h0, 16'h0030, 32'h0);
    cmd_valid = 2'b10;
    wait_ok = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge aclk);
      if (cmd_ready[1]) begin
        wait_ok = 1;
        break;
      end
    end
    chk("hs_first_grant", 32'(wait_ok), 32'd1);
    seq = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      seq[c] = cmd_ready[1];
    end
    chk("hs_regrant_seq", 32'(seq), 32'b0100);
    @(posedge aclk); #1 cmd_valid = '0;
    drain();

    // Reset during the capture cycle of a read drops the response.
    set_cmd(0, 4'h0, 16'h0010, 32'h0);
    cmd_valid = 2'b01;
    wait_ok = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge aclk);
      if (cmd_ready[0]) begin
        wait_ok = 1;
        break;
      end
    end
    chk("mr_grant", 32'(wait_ok), 32'd1);
    @(posedge aclk); #1;
    aresetn   = 1'b0;
    cmd_valid = '0;
    @(negedge aclk);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    any_rsp = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      any_rsp = any_rsp | rsp_valid;
    end
    chk("mr_no_rsp", 32'(any_rsp), 32'd0);
    do_txn(0, 4'h0, 16'h0010, 32'h0, 32'hDEADBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
